// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared types and helpers for the packet-aware round-robin stream arbiter.
//   arb_state_e : arbiter FSM state (free to arbitrate / locked to one packet)
//   rr_next     : modulo-n increment of a requester index
// -----------------------------------------------------------------------------
package stream_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

   // Index of the requester after ptr, wrapping n-1 back to 0.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/rr_grant_select.sv
// -----------------------------------------------------------------------------
// rr_grant_select
// Combinational round-robin search: picks the first valid requester found
// starting at rr_ptr and moving upward, wrapping past NUM_REQ-1 to 0.
// Ports:
//   req_valid   in  NUM_REQ   per-requester valid
//   rr_ptr      in  ID_WIDTH  highest-priority index this cycle
//   grant_valid out 1         at least one requester is valid
//   grant_idx   out ID_WIDTH  selected requester (0 when none)
// -----------------------------------------------------------------------------
module rr_grant_select #(
   parameter  int NUM_REQ  = 4,
   localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req_valid,
   input  logic [ID_WIDTH-1:0] rr_ptr,
   output logic                grant_valid,
   output logic [ID_WIDTH-1:0] grant_idx
);

   logic                found_hi, found_lo;
   logic [ID_WIDTH-1:0] idx_hi, idx_lo;

   // Split the ring at rr_ptr: the lowest valid index at or above the pointer
   // wins; otherwise the search wraps and the lowest valid index below it wins.
   // Scanning downward lets the last hit in each half be the lowest index.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path through the block can infer a latch.
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (ID_WIDTH'(i) >= rr_ptr) begin
               found_hi = 1'b1;
               idx_hi   = ID_WIDTH'(i);
            end else begin
               found_lo = 1'b1;
               idx_lo   = ID_WIDTH'(i);
            end
         end
      end
      grant_valid = found_hi | found_lo;
      grant_idx   = found_hi ? idx_hi : idx_lo;
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
// Shares one registered valid/ready stage between NUM_REQ requesters using
// round-robin arbitration. A packet that starts with last=0 locks the grant to
// its requester until the beat carrying last=1 is accepted.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   req_valid   in  NUM_REQ             per-requester beat valid
//   req_ready   out NUM_REQ             per-requester accept (one-hot or zero)
//   req_data    in  NUM_REQ*DATA_WIDTH  packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last    in  NUM_REQ             per-requester end-of-packet
//   out_valid   out 1                   registered beat valid
//   out_ready   in  1                   downstream accept
//   out_data    out DATA_WIDTH          registered payload
//   out_last    out 1                   registered end-of-packet
//   out_id      out ID_WIDTH            requester that sourced the beat
// -----------------------------------------------------------------------------
module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 32,
   localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   output logic [ID_WIDTH-1:0]           out_id
);

   arb_state_e            state, state_nxt;
   logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
   logic [ID_WIDTH-1:0]   lock_id, lock_id_nxt;
   logic                  grant_valid;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic                  load_en;
   logic                  sel_valid;
   logic [ID_WIDTH-1:0]   sel_idx;
   logic                  accept;
   logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

   rr_grant_select #(
      .NUM_REQ(NUM_REQ)
   ) u_grant_select (
      .req_valid  (req_valid),
      .rr_ptr     (rr_ptr),
      .grant_valid(grant_valid),
      .grant_idx  (grant_idx)
   );

   // The output stage can take a beat when it is empty or being drained.
   assign load_en = !out_valid || out_ready;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Next-state, pointer update and per-requester ready.
   always_comb begin
      state_nxt   = state;
      rr_ptr_nxt  = rr_ptr;
      lock_id_nxt = lock_id;
      sel_valid   = 1'b0;
      sel_idx     = grant_idx;
      req_ready   = '0;

      case (state)
         ARB_IDLE: begin
            sel_valid = grant_valid;
            sel_idx   = grant_idx;
            req_ready[grant_idx] = grant_valid && load_en && !rst;
         end
         ARB_LOCKED: begin
            // Only the packet owner is considered; a gap in its valid just waits.
            sel_valid = req_valid[lock_id];
            sel_idx   = lock_id;
            req_ready[lock_id] = load_en && !rst;
         end
      endcase

      accept = sel_valid && load_en;

      if (accept) begin
         if (state == ARB_IDLE) begin
            if (req_last[sel_idx]) begin
               rr_ptr_nxt = ID_WIDTH'(rr_next(32'(sel_idx), NUM_REQ));
            end else begin
               state_nxt   = ARB_LOCKED;
               lock_id_nxt = sel_idx;
            end
         end else if (req_last[sel_idx]) begin
            state_nxt  = ARB_IDLE;
            rr_ptr_nxt = ID_WIDTH'(rr_next(32'(lock_id), NUM_REQ));
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ARB_IDLE;
         rr_ptr  <= '0;
         lock_id <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         lock_id <= lock_id_nxt;
      end
   end

   // Output register: payload only changes on an accepted beat, so a stalled
   // beat and an empty stage both hold their last contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_id    <= '0;
      end else if (load_en) begin
         out_valid <= accept;
         if (accept) begin
            out_data <= req_data_arr[sel_idx];
            out_last <= req_last[sel_idx];
            out_id   <= sel_idx;
         end
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
// Self-checking bench for stream_rr_arbiter. Each requester owns a queue of
// beats and holds valid on its head beat until accepted. A reference model
// built from the arbitration rules (round-robin search with modulo arithmetic,
// packet lock, one registered output stage) predicts req_ready every cycle and
// the output stage after every edge. Directed scenarios additionally compare
// the delivered beat sequence against fixed expected lists.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [IW-1:0]   out_id;

   stream_rr_arbiter #(
      .NUM_REQ   (N),
      .DATA_WIDTH(DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_data (req_data),
      .req_last (req_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .out_id   (out_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Traffic sources.
   beat_t src_q [N][$];
   bit    present  [N];
   bit    hold_off [N];
   int    present_pct = 100;

   // Reference model state.
   bit            m_locked;
   int            m_owner;
   int            m_ptr;
   bit            m_ov;
   logic [DW-1:0] m_od;
   bit            m_ol;
   int            m_oid;

   // Beats observed leaving the output.
   int            log_id   [$];
   logic [DW-1:0] log_data [$];
   int            log_cyc  [$];

   task automatic model_reset();
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
      m_ov     = 1'b0;
      m_od     = '0;
      m_ol     = 1'b0;
      m_oid    = 0;
      log_id.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      out_ready = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         present[i]  = 1'b0;
         hold_off[i] = 1'b0;
      end
      present_pct = 100;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (!present[i] && !hold_off[i] && src_q[i].size() > 0 &&
             int'($urandom_range(99, 0)) < present_pct)
            present[i] = 1'b1;
         req_valid[i] = present[i];
         if (present[i]) begin
            req_data[i*DW +: DW] = src_q[i][0].data;
            req_last[i]          = src_q[i][0].last;
         end else begin
            req_data[i*DW +: DW] = $urandom;
            req_last[i]          = 1'($urandom);
         end
      end
   endtask

   // One clock cycle: drive, predict/check ready, clock, predict/check output.
   // Entered and left at posedge+1.
   task automatic cycle();
      logic [N-1:0] exp_ready;
      int           acc;
      int           idx;
      bit           load;
      beat_t        b;

      cyc++;
      drive_inputs();
      #1;
      load      = !m_ov || out_ready;
      exp_ready = '0;
      if (m_locked) begin
         exp_ready[m_owner] = load;
      end else if (load) begin
         for (int j = 0; j < N; j++) begin
            idx = (m_ptr + j) % N;
            if (req_valid[idx]) begin
               exp_ready[idx] = 1'b1;
               break;
            end
         end
      end
      checks++;
      if (req_ready !== exp_ready) begin
         errors++;
         $display("FAIL req_ready cyc=%0d got %b expected %b", cyc, req_ready, exp_ready);
      end
      acc = -1;
      for (int i = 0; i < N; i++)
         if (exp_ready[i] && req_valid[i]) acc = i;
      if (out_valid && out_ready) begin
         log_id.push_back(int'(out_id));
         log_data.push_back(out_data);
         log_cyc.push_back(cyc);
      end

      @(posedge clk);
      #1;

      if (acc >= 0) begin
         b = src_q[acc].pop_front();
         present[acc] = 1'b0;
         if (m_locked) begin
            if (b.last) begin
               m_locked = 1'b0;
               m_ptr    = (m_owner + 1) % N;
            end
         end else if (b.last) begin
            m_ptr = (acc + 1) % N;
         end else begin
            m_locked = 1'b1;
            m_owner  = acc;
         end
      end
      if (load) begin
         m_ov = (acc >= 0);
         if (acc >= 0) begin
            m_od  = b.data;
            m_ol  = b.last;
            m_oid = acc;
         end
      end

      checks++;
      if (out_valid !== m_ov) begin
         errors++;
         $display("FAIL out_valid cyc=%0d got %b expected %b", cyc, out_valid, m_ov);
      end
      if (m_ov) begin
         checks++;
         if ({out_last, out_id, out_data} !== {m_ol, IW'(m_oid), m_od}) begin
            errors++;
            $display("FAIL out_beat cyc=%0d got last=%b id=%0d data=%h expected last=%b id=%0d data=%h",
                     cyc, out_last, out_id, out_data, m_ol, m_oid, m_od);
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '1;
      req_last  = '1;
      req_data  = '1;
      out_ready = 1'b1;
      #3;
      checks++;
      if ({out_valid, out_last, out_id, out_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%b last=%b id=%0d data=%h expected all zero",
                  out_valid, out_last, out_id, out_data);
      end
      checks++;
      if (req_ready !== '0) begin
         errors++;
         $display("FAIL reset_ready got %b expected 0000", req_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL post_reset_ready got %b expected 0001", req_ready);
      end
      apply_reset();
      repeat (2) cycle();
   endtask

   task automatic test_round_robin();
      int            exp_id [4];
      logic [DW-1:0] exp_d  [4];
      apply_reset();
      exp_id = '{0, 1, 2, 3};
      exp_d  = '{32'h10, 32'h11, 32'h12, 32'h13};
      for (int i = 0; i < N; i++) src_q[i].push_back('{1'b1, exp_d[i]});
      repeat (6) cycle();
      checks++;
      if (log_id.size() != 4) begin
         errors++;
         $display("FAIL rr_count got %0d expected 4", log_id.size());
      end
      for (int k = 0; k < 4 && k < log_id.size(); k++) begin
         checks++;
         if (log_id[k] !== exp_id[k] || log_data[k] !== exp_d[k]) begin
            errors++;
            $display("FAIL rr_seq[%0d] got id=%0d data=%h expected id=%0d data=%h",
                     k, log_id[k], log_data[k], exp_id[k], exp_d[k]);
         end
      end
      if (log_cyc.size() == 4) begin
         checks++;
         if (log_cyc[3] - log_cyc[0] != 3) begin
            errors++;
            $display("FAIL rr_throughput got span %0d expected 3", log_cyc[3] - log_cyc[0]);
         end
      end
   endtask

   task automatic test_packet_lock();
      int            exp_id [4];
      logic [DW-1:0] exp_d  [4];
      apply_reset();
      exp_id = '{1, 1, 1, 2};
      exp_d  = '{32'hA0, 32'hA1, 32'hA2, 32'hB0};
      src_q[1].push_back('{1'b0, 32'hA0});
      src_q[1].push_back('{1'b0, 32'hA1});
      src_q[1].push_back('{1'b1, 32'hA2});
      src_q[2].push_back('{1'b1, 32'hB0});
      repeat (7) cycle();
      checks++;
      if (log_id.size() != 4) begin
         errors++;
         $display("FAIL lock_count got %0d expected 4", log_id.size());
      end
      for (int k = 0; k < 4 && k < log_id.size(); k++) begin
         checks++;
         if (log_id[k] !== exp_id[k] || log_data[k] !== exp_d[k]) begin
            errors++;
            $display("FAIL lock_seq[%0d] got id=%0d data=%h expected id=%0d data=%h",
                     k, log_id[k], log_data[k], exp_id[k], exp_d[k]);
         end
      end
   endtask

   task automatic test_stall();
      int base;
      apply_reset();
      base = cyc;
      src_q[0].push_back('{1'b1, 32'hDEADBEEF});
      src_q[1].push_back('{1'b1, 32'h00001234});
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      repeat (4) cycle();
      checks++;
      if (req_ready !== '0) begin
         errors++;
         $display("FAIL stall_ready got %b expected 0000", req_ready);
      end
      out_ready = 1'b1;
      repeat (3) cycle();
      checks++;
      if (log_id.size() != 2) begin
         errors++;
         $display("FAIL stall_count got %0d expected 2", log_id.size());
      end else begin
         checks++;
         if (log_id[0] !== 0 || log_data[0] !== 32'hDEADBEEF || log_cyc[0] !== base + 6) begin
            errors++;
            $display("FAIL stall_release got id=%0d data=%h cyc=%0d expected id=0 data=deadbeef cyc=%0d",
                     log_id[0], log_data[0], log_cyc[0], base + 6);
         end
         checks++;
         if (log_id[1] !== 1 || log_data[1] !== 32'h00001234) begin
            errors++;
            $display("FAIL stall_next got id=%0d data=%h expected id=1 data=00001234",
                     log_id[1], log_data[1]);
         end
      end
   endtask

   task automatic test_wrap();
      int            exp_id [4];
      logic [DW-1:0] exp_d  [4];
      apply_reset();
      exp_id = '{2, 3, 0, 2};
      exp_d  = '{32'h20, 32'h30, 32'h40, 32'h41};
      src_q[2].push_back('{1'b1, 32'h20});
      repeat (2) cycle();
      src_q[3].push_back('{1'b1, 32'h30});
      repeat (2) cycle();
      src_q[0].push_back('{1'b1, 32'h40});
      src_q[2].push_back('{1'b1, 32'h41});
      repeat (4) cycle();
      checks++;
      if (log_id.size() != 4) begin
         errors++;
         $display("FAIL wrap_count got %0d expected 4", log_id.size());
      end
      for (int k = 0; k < 4 && k < log_id.size(); k++) begin
         checks++;
         if (log_id[k] !== exp_id[k] || log_data[k] !== exp_d[k]) begin
            errors++;
            $display("FAIL wrap_seq[%0d] got id=%0d data=%h expected id=%0d data=%h",
                     k, log_id[k], log_data[k], exp_id[k], exp_d[k]);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      src_q[0].push_back('{1'b0, 32'hC0});
      src_q[0].push_back('{1'b0, 32'hC1});
      src_q[0].push_back('{1'b0, 32'hC2});
      src_q[0].push_back('{1'b1, 32'hC3});
      src_q[2].push_back('{1'b1, 32'h55});
      cycle();
      req_valid = 4'b0101;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || req_ready !== '0) begin
         errors++;
         $display("FAIL async_reset got out_valid=%b req_ready=%b expected 0 and 0000",
                  out_valid, req_ready);
      end
      src_q[0].delete();
      present[0] = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) cycle();
      checks++;
      if (log_id.size() != 1) begin
         errors++;
         $display("FAIL async_count got %0d expected 1", log_id.size());
      end else begin
         checks++;
         if (log_id[0] !== 2 || log_data[0] !== 32'h55) begin
            errors++;
            $display("FAIL async_regrant got id=%0d data=%h expected id=2 data=00000055",
                     log_id[0], log_data[0]);
         end
      end
   endtask

   task automatic test_gap();
      int            exp_id [4];
      logic [DW-1:0] exp_d  [4];
      apply_reset();
      exp_id = '{0, 0, 0, 1};
      exp_d  = '{32'hD0, 32'hD1, 32'hD2, 32'hE0};
      src_q[0].push_back('{1'b0, 32'hD0});
      src_q[0].push_back('{1'b0, 32'hD1});
      src_q[0].push_back('{1'b1, 32'hD2});
      src_q[1].push_back('{1'b1, 32'hE0});
      cycle();
      hold_off[0] = 1'b1;
      repeat (2) cycle();
      checks++;
      if (req_ready[1] !== 1'b0) begin
         errors++;
         $display("FAIL gap_leak got req_ready[1]=%b expected 0", req_ready[1]);
      end
      hold_off[0] = 1'b0;
      repeat (6) cycle();
      checks++;
      if (log_id.size() != 4) begin
         errors++;
         $display("FAIL gap_count got %0d expected 4", log_id.size());
      end
      for (int k = 0; k < 4 && k < log_id.size(); k++) begin
         checks++;
         if (log_id[k] !== exp_id[k] || log_data[k] !== exp_d[k]) begin
            errors++;
            $display("FAIL gap_seq[%0d] got id=%0d data=%h expected id=%0d data=%h",
                     k, log_id[k], log_data[k], exp_id[k], exp_d[k]);
         end
      end
   endtask

   task automatic test_random();
      int  total;
      int  len;
      int  budget;
      bit  busy;
      apply_reset();
      total = 0;
      for (int i = 0; i < N; i++) begin
         for (int p = 0; p < 30; p++) begin
            len = int'($urandom_range(4, 1));
            for (int b = 0; b < len; b++) begin
               src_q[i].push_back('{(b == len - 1), $urandom});
               total++;
            end
         end
      end
      present_pct = 60;
      budget      = 5000;
      busy        = 1'b1;
      while (busy && budget > 0) begin
         out_ready = ($urandom_range(3, 0) != 0);
         cycle();
         budget--;
         busy = 1'b0;
         for (int i = 0; i < N; i++)
            if (src_q[i].size() > 0) busy = 1'b1;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL random_timeout got pending traffic after 5000 cycles expected drained");
      end
      out_ready = 1'b1;
      repeat (2) cycle();
      checks++;
      if (log_id.size() != total) begin
         errors++;
         $display("FAIL random_count got %0d beats expected %0d", log_id.size(), total);
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      out_ready = 1'b1;
      test_reset();
      test_round_robin();
      test_packet_lock();
      test_stall();
      test_wrap();
      test_async_reset();
      test_gap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
